// File: rtl/quant_blk_scheduler_if.sv
// Block-level bundle between the upstream block source, the quantizer core and the
// downstream result sink; the scheduler connects through the slave modport.
interface quant_blk_scheduler_if #(
  parameter int L2_WIDTH         = 512,
  parameter int WordWidth_WIDTH  = 32,
  parameter int NumOfWordsinBlk  = 16,
  parameter int ExponentLength   = 8,
  parameter int NumOfBytesInWord = 4
);
  localparam int WW = WordWidth_WIDTH * NumOfWordsinBlk;
  localparam int BW = 5 * NumOfWordsinBlk;
  localparam int SW = ExponentLength * NumOfWordsinBlk;
  localparam int IW = NumOfBytesInWord * NumOfWordsinBlk;

  logic                       in_valid;
  logic                       in_ready;
  logic [WW-1:0]              in_words;
  logic [WW-1:0]              in_mid;
  logic [BW-1:0]              in_bitwidth;
  logic [SW-1:0]              in_stepsize;
  logic [NumOfWordsinBlk-1:0] in_conv;
  logic [IW-1:0]              in_isbool;

  logic                       q_in_progress;
  logic [WW-1:0]              q_words;
  logic [WW-1:0]              q_mid;
  logic [BW-1:0]              q_bitwidth;
  logic [SW-1:0]              q_stepsize;
  logic [NumOfWordsinBlk-1:0] q_conv;
  logic [IW-1:0]              q_isbool;
  logic [L2_WIDTH-1:0]        q_out_str;
  logic [8:0]                 q_num_bits;
  logic [NumOfWordsinBlk-1:0] q_outlier;

  logic                       out_valid;
  logic                       out_ready;
  logic [L2_WIDTH-1:0]        out_str;
  logic [8:0]                 out_num_bits;
  logic [NumOfWordsinBlk-1:0] out_outlier;
  logic [4:0]                 out_outlier_cnt;

  modport slave (
    input  in_valid, in_words, in_mid, in_bitwidth, in_stepsize, in_conv, in_isbool,
    input  q_out_str, q_num_bits, q_outlier, out_ready,
    output in_ready, q_in_progress, q_words, q_mid, q_bitwidth, q_stepsize, q_conv, q_isbool,
    output out_valid, out_str, out_num_bits, out_outlier, out_outlier_cnt
  );

  modport master (
    output in_valid, in_words, in_mid, in_bitwidth, in_stepsize, in_conv, in_isbool,
    output q_out_str, q_num_bits, q_outlier, out_ready,
    input  in_ready, q_in_progress, q_words, q_mid, q_bitwidth, q_stepsize, q_conv, q_isbool,
    input  out_valid, out_str, out_num_bits, out_outlier, out_outlier_cnt
  );
endinterface

// File: rtl/quant_blk_scheduler.sv
// Sequences one block at a time through the quantizer: latch descriptor, run N cycles, capture, present.
// Define QSCHED_PERF_CNT_EN to add the perf_blk_cnt / perf_stall_cnt counters.
module quant_blk_scheduler #(
  parameter int L2_WIDTH         = 512,
  parameter int WordWidth_WIDTH  = 32,
  parameter int NumOfWordsinBlk  = 16,
  parameter int ExponentLength   = 8,
  parameter int NumOfBytesInWord = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic abort,
  output logic busy,
`ifdef QSCHED_PERF_CNT_EN
  output logic [31:0] perf_blk_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  quant_blk_scheduler_if.slave bus
);
  localparam int WW = WordWidth_WIDTH * NumOfWordsinBlk;
  localparam int BW = 5 * NumOfWordsinBlk;
  localparam int SW = ExponentLength * NumOfWordsinBlk;
  localparam int IW = NumOfBytesInWord * NumOfWordsinBlk;
  localparam int CW = $clog2(NumOfWordsinBlk);
  localparam logic [CW-1:0] CNT_LAST = CW'(NumOfWordsinBlk - 1);

  typedef enum logic [1:0] {IDLE, RUN, CAP, OUT} state_t;

  state_t                     state_reg, state_next;
  logic [CW-1:0]              cnt_reg, cnt_next;
  logic                       accept, capture;
  logic [4:0]                 outlier_cnt_next;

  logic [WW-1:0]              words_reg, mid_reg;
  logic [BW-1:0]              bitwidth_reg;
  logic [SW-1:0]              stepsize_reg;
  logic [NumOfWordsinBlk-1:0] conv_reg;
  logic [IW-1:0]              isbool_reg;
  logic [L2_WIDTH-1:0]        str_reg;
  logic [8:0]                 num_bits_reg;
  logic [NumOfWordsinBlk-1:0] outlier_reg;
  logic [4:0]                 outlier_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Abort overrides everything, including a handshake offered in the same cycle.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    accept       = 1'b0;
    capture      = 1'b0;
    bus.in_ready = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            accept     = 1'b1;
            cnt_next   = '0;
            state_next = RUN;
          end
        end
        RUN: begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == CNT_LAST) state_next = CAP;
        end
        CAP: begin
          capture    = 1'b1;
          state_next = OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
              accept     = 1'b1;
              cnt_next   = '0;
              state_next = RUN;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_reg    <= '0;
      mid_reg      <= '0;
      bitwidth_reg <= '0;
      stepsize_reg <= '0;
      conv_reg     <= '0;
      isbool_reg   <= '0;
    end else if (accept) begin
      words_reg    <= bus.in_words;
      mid_reg      <= bus.in_mid;
      bitwidth_reg <= bus.in_bitwidth;
      stepsize_reg <= bus.in_stepsize;
      conv_reg     <= bus.in_conv;
      isbool_reg   <= bus.in_isbool;
    end
  end

  always_comb begin
    outlier_cnt_next = '0;
    for (int i = 0; i < NumOfWordsinBlk; i++)
      outlier_cnt_next = outlier_cnt_next + 5'(bus.q_outlier[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      str_reg         <= '0;
      num_bits_reg    <= '0;
      outlier_reg     <= '0;
      outlier_cnt_reg <= '0;
    end else if (capture) begin
      str_reg         <= bus.q_out_str;
      num_bits_reg    <= bus.q_num_bits;
      outlier_reg     <= bus.q_outlier;
      outlier_cnt_reg <= outlier_cnt_next;
    end
  end

  assign busy                = (state_reg != IDLE);
  assign bus.q_in_progress   = (state_reg == RUN);
  assign bus.out_valid       = (state_reg == OUT);
  assign bus.q_words         = words_reg;
  assign bus.q_mid           = mid_reg;
  assign bus.q_bitwidth      = bitwidth_reg;
  assign bus.q_stepsize      = stepsize_reg;
  assign bus.q_conv          = conv_reg;
  assign bus.q_isbool        = isbool_reg;
  assign bus.out_str         = str_reg;
  assign bus.out_num_bits    = num_bits_reg;
  assign bus.out_outlier     = outlier_reg;
  assign bus.out_outlier_cnt = outlier_cnt_reg;

`ifdef QSCHED_PERF_CNT_EN
  logic [31:0] blk_cnt_reg, stall_cnt_reg;

  // Only rst_n clears these; abort leaves the history intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (state_reg == OUT && bus.out_ready && !abort) blk_cnt_reg <= blk_cnt_reg + 32'd1;
      if (state_reg == OUT && !bus.out_ready) stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_blk_cnt   = blk_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_quant_blk_scheduler.sv
// Randomized scoreboard bench for quant_blk_scheduler; the bench also plays the quantizer core.
module tb_quant_blk_scheduler;
  localparam int LAT = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic busy;
`ifdef QSCHED_PERF_CNT_EN
  logic [31:0] perf_blk_cnt, perf_stall_cnt;
`endif

  quant_blk_scheduler_if #(.L2_WIDTH(512), .WordWidth_WIDTH(32), .NumOfWordsinBlk(16),
                           .ExponentLength(8), .NumOfBytesInWord(4)) bus ();

  quant_blk_scheduler #(.L2_WIDTH(512), .WordWidth_WIDTH(32), .NumOfWordsinBlk(16),
                        .ExponentLength(8), .NumOfBytesInWord(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (abort),
    .busy  (busy),
`ifdef QSCHED_PERF_CNT_EN
    .perf_blk_cnt   (perf_blk_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] str;
    logic [8:0]   nb;
    logic [15:0]  outl;
    logic [4:0]   cnt;
    int           acc;
  } exp_t;

  typedef struct {
    logic [511:0] words;
    logic [511:0] mid;
    logic [287:0] rest;
  } desc_t;

  exp_t  sb[$];
  desc_t cur;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    run_len = 0;
  int    last_acc = 0;
  bit    have_last = 0;
  bit    b2b = 0;
  bit    truncated = 0;
  bit    front_seen = 0;

  function automatic logic [8:0] sum_bw(logic [79:0] bw);
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(bw[i*5 +: 5]);
    return 9'(s);
  endfunction

  // Quantizer stand-in: results are a fixed function of the held descriptor.
  always_comb begin
    bus.q_out_str  = bus.q_words ^ bus.q_mid;
    bus.q_outlier  = bus.q_mid[15:0];
    bus.q_num_bits = sum_bw(bus.q_bitwidth);
  end

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Input side: record expectations on every accepted block and watch the held descriptor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.q_in_progress) begin
        run_len++;
        chk("q_words_stable", bus.q_words, cur.words);
        chk("q_mid_stable", bus.q_mid, cur.mid);
        chk("q_rest_stable", {bus.q_bitwidth, bus.q_stepsize, bus.q_conv, bus.q_isbool}, cur.rest);
        chk("in_ready_run", bus.in_ready, 0);
      end else if (run_len != 0) begin
        if (!truncated) chk("run_length", run_len, 16);
        run_len = 0;
        truncated = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.str  = bus.in_words ^ bus.in_mid;
        e.nb   = sum_bw(bus.in_bitwidth);
        e.outl = bus.in_mid[15:0];
        e.cnt  = 5'($countones(bus.in_mid[15:0]));
        e.acc  = cyc;
        sb.push_back(e);
        cur.words = bus.in_words;
        cur.mid   = bus.in_mid;
        cur.rest  = {bus.in_bitwidth, bus.in_stepsize, bus.in_conv, bus.in_isbool};
        if (b2b && have_last) chk("b2b_period", cyc - last_acc, LAT);
        last_acc  = cyc;
        have_last = 1;
        $display("accept   cycle %0d num_bits %0d outlier %h", cyc, e.nb, e.outl);
      end
    end
  end

  // Output side: compare presented results against the scoreboard front.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      chk("out_valid_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        chk("out_str", bus.out_str, sb[0].str);
        chk("out_num_bits", bus.out_num_bits, sb[0].nb);
        chk("out_outlier", bus.out_outlier, sb[0].outl);
        chk("out_outlier_cnt", bus.out_outlier_cnt, sb[0].cnt);
        if (!front_seen) chk("latency", cyc - sb[0].acc, LAT);
        if (!bus.out_ready) chk("in_ready_backpressure", bus.in_ready, 0);
        if (bus.out_ready) begin
          $display("result   cycle %0d num_bits %0d outlier %h cnt %0d", cyc,
                   bus.out_num_bits, bus.out_outlier, bus.out_outlier_cnt);
          void'(sb.pop_front());
          front_seen = 0;
        end else begin
          front_seen = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      bus.in_words[i*32 +: 32]  = $urandom;
      bus.in_mid[i*32 +: 32]    = $urandom;
      bus.in_bitwidth[i*5 +: 5] = 5'($urandom);
      bus.in_stepsize[i*8 +: 8] = 8'($urandom);
      bus.in_isbool[i*4 +: 4]   = 4'($urandom);
    end
    bus.in_conv = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (busy && n < 200) begin
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic flush();
    sb.delete();
    front_seen = 0;
    truncated  = 1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_q_in_progress", bus.q_in_progress, 0);
    chk("rst_out_str", bus.out_str, 0);
    chk("rst_q_words", bus.q_words, 0);
    chk("rst_out_num_bits", bus.out_num_bits, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", bus.in_ready, 1);

    // Directed block: all widths 8, outlier pattern A5A5.
    step();
    for (int i = 0; i < 16; i++) bus.in_bitwidth[i*5 +: 5] = 5'd8;
    bus.in_mid[15:0] = 16'hA5A5;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_idle();

    // Back-to-back with in_* scrambled every cycle.
    b2b = 1;
    have_last = 0;
    repeat (5 * LAT) begin
      step();
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
    end
    b2b = 0;
    wait_idle();

    // Backpressure: hold out_ready low for the first 10 OUT cycles.
    step();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    begin
      int n = 0;
`ifdef QSCHED_PERF_CNT_EN
      logic [31:0] stall0 = perf_stall_cnt;
`endif
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      while (!bus.out_valid && n < 40) begin
        step();
        bus.out_ready = 1'b0;
        n++;
      end
      chk("bp_out_valid_timeout", bus.out_valid, 1);
      repeat (9) begin
        step();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
      end
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
`ifdef QSCHED_PERF_CNT_EN
      step();
      chk("perf_stall", perf_stall_cnt - stall0, 10);
`endif
    end
    wait_idle();

    // Abort during RUN cycle 7.
    step();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (7) step();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", bus.in_ready, 0);
    step();
    abort = 1'b0;
    flush();
    chk("abort_q_in_progress", bus.q_in_progress, 0);
    chk("abort_busy", busy, 0);
    repeat (25) step();

    // Asynchronous reset during RUN cycle 5.
    step();
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    flush();
    chk("arst_q_in_progress", bus.q_in_progress, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_num_bits", bus.out_num_bits, 0);
    chk("arst_q_words", bus.q_words, 0);
    chk("arst_out_str", bus.out_str, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("arst_in_ready", bus.in_ready, 1);
    repeat (25) step();

    // Random traffic with random backpressure.
    repeat (600) begin
      step();
      bus.in_valid  = ($urandom_range(0, 9) < 6);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    wait_idle();
    step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
